regfile_wb_arbiter: RTL and testbench

- Arbitrates the single register-file write port between two writeback requesters: A (ALU result) and B (load data).
- Keeps a pending-write scoreboard so Instruction Decode can detect read-after-write hazards on rs1/rs2.
- Sits between the execute/memory stages and the register file. It drives the register file's RegWrite, rd and wrt_data inputs directly.

---
 rtl/regfile_wb_arbiter.sv | 96 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the single register-file write port, with a
// pending-write scoreboard that decode uses for RAW hazard detection.
module regfile_wb_arbiter #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    input  logic [AW-1:0]   a_rd,
    input  logic [XLEN-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [AW-1:0]   b_rd,
    input  logic [XLEN-1:0] b_data,
    output logic            b_ready,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   chk_rs1,
    input  logic [AW-1:0]   chk_rs2,
    output logic            hazard,
    output logic            RegWrite,
    output logic [AW-1:0]   rd,
    output logic [XLEN-1:0] wrt_data,
    output logic [NREG-1:0] pending,
    output logic            x0_drop
);

    logic            favor_b_q;
    logic            regwrite_q;
    logic [AW-1:0]   rd_q;
    logic [XLEN-1:0] data_q;
    logic [NREG-1:0] pending_q, pending_d;
    logic            x0_drop_q;

    logic            grant_a, grant_b, accept, sel_nonzero;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;

    // Grants depend only on the valids and the pointer, never on the other ready.
    always_comb begin
        grant_a     = !rst && a_valid && (!b_valid || !favor_b_q);
        grant_b     = !rst && b_valid && (!a_valid || favor_b_q);
        accept      = grant_a || grant_b;
        sel_rd      = grant_a ? a_rd : b_rd;
        sel_data    = grant_a ? a_data : b_data;
        sel_nonzero = (sel_rd != '0);
    end

    // Set is applied after clear so a same-cycle issue to the same index wins.
    always_comb begin
        pending_d = pending_q;
        if (accept && sel_nonzero) begin
            pending_d[sel_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            favor_b_q  <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            data_q     <= '0;
            pending_q  <= '0;
            x0_drop_q  <= 1'b0;
        end else begin
            regwrite_q <= accept && sel_nonzero;
            x0_drop_q  <= accept && !sel_nonzero;
            if (accept && sel_nonzero) begin
                rd_q   <= sel_rd;
                data_q <= sel_data;
            end
            if (a_valid && b_valid) begin
                favor_b_q <= grant_a;
            end
            pending_q <= pending_d;
        end
    end

    always_comb begin
        a_ready  = grant_a;
        b_ready  = grant_b;
        hazard   = pending_q[chk_rs1] | pending_q[chk_rs2];
        RegWrite = regwrite_q;
        rd       = rd_q;
        wrt_data = data_q;
        pending  = pending_q;
        x0_drop  = x0_drop_q;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and random bench for regfile_wb_arbiter; a behavioural model pushes
// expected register-file outputs to a queue that is popped after each posedge.
module tb_regfile_wb_arbiter;

    localparam int unsigned XLEN = 64;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    logic            clk;
    logic            rst;
    logic            a_valid, b_valid, issue_valid;
    logic [AW-1:0]   a_rd, b_rd, issue_rd, chk_rs1, chk_rs2;
    logic [XLEN-1:0] a_data, b_data;
    logic            a_ready, b_ready, hazard, RegWrite, x0_drop;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] wrt_data;
    logic [NREG-1:0] pending;

    typedef struct packed {
        logic            we;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
        logic            x0;
        logic [NREG-1:0] pend;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    logic            m_favor_b;
    logic [NREG-1:0] m_pending;
    logic [AW-1:0]   m_rd;
    logic [XLEN-1:0] m_data;

    regfile_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .a_valid     (a_valid),
        .a_rd        (a_rd),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_rd        (b_rd),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .hazard      (hazard),
        .RegWrite    (RegWrite),
        .rd          (rd),
        .wrt_data    (wrt_data),
        .pending     (pending),
        .x0_drop     (x0_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        a_valid     = 1'b0;
        b_valid     = 1'b0;
        issue_valid = 1'b0;
    endtask

    // One cycle: check combinational outputs at negedge, push the model's
    // expectation, then pop and compare just after the posedge.
    task automatic tick();
        logic            ea, eb, acc, we, x0, ehz;
        logic [AW-1:0]   r;
        logic [XLEN-1:0] d;
        exp_t            e, got;
        @(negedge clk);
        ea = !rst && a_valid && (!b_valid || !m_favor_b);
        eb = !rst && b_valid && (!a_valid || m_favor_b);
        check("a_ready", {127'b0, a_ready}, {127'b0, ea});
        check("b_ready", {127'b0, b_ready}, {127'b0, eb});
        if (!rst) begin
            ehz = ((chk_rs1 != 0) && m_pending[chk_rs1]) || ((chk_rs2 != 0) && m_pending[chk_rs2]);
            check("hazard", {127'b0, hazard}, {127'b0, ehz});
        end
        if (rst) begin
            m_favor_b = 1'b0;
            m_pending = '0;
            m_rd      = '0;
            m_data    = '0;
            we        = 1'b0;
            x0        = 1'b0;
        end else begin
            acc = ea || eb;
            r   = ea ? a_rd : b_rd;
            d   = ea ? a_data : b_data;
            we  = acc && (r != 0);
            x0  = acc && (r == 0);
            if (we) begin
                m_rd         = r;
                m_data       = d;
                m_pending[r] = 1'b0;
            end
            if (issue_valid && issue_rd != 0) m_pending[issue_rd] = 1'b1;
            if (a_valid && b_valid) m_favor_b = ea;
        end
        e.we   = we;
        e.rd   = m_rd;
        e.data = m_data;
        e.x0   = x0;
        e.pend = m_pending;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            got = exp_q.pop_front();
            check("RegWrite", {127'b0, RegWrite}, {127'b0, got.we});
            check("rd", {123'b0, rd}, {123'b0, got.rd});
            check("wrt_data", {64'b0, wrt_data}, {64'b0, got.data});
            check("x0_drop", {127'b0, x0_drop}, {127'b0, got.x0});
            check("pending", {96'b0, pending}, {96'b0, got.pend});
        end
    endtask

    initial begin
        m_favor_b = 1'b0;
        m_pending = '0;
        m_rd      = '0;
        m_data    = '0;
        chk_rs1   = '0;
        chk_rs2   = '0;
        issue_rd  = '0;
        a_data    = '0;
        b_data    = '0;
        idle();

        // Reset with both requesters valid
        rst = 1'b1;
        a_valid = 1'b1; a_rd = 5'd1; b_valid = 1'b1; b_rd = 5'd2;
        tick();
        tick();
        rst = 1'b0;
        idle();
        tick();
        check("reset_regwrite", {127'b0, RegWrite}, 128'd0);
        check("reset_pending", {96'b0, pending}, 128'd0);

        // Single write
        a_valid = 1'b1; a_rd = 5'd5; a_data = 64'h1234;
        tick();
        check("single_rd", {123'b0, rd}, 128'd5);
        check("single_data", {64'b0, wrt_data}, 128'h1234);
        idle();
        tick();
        check("single_after", {127'b0, RegWrite}, 128'd0);

        // Contention: A,B,A,B
        a_valid = 1'b1; a_rd = 5'd3; a_data = 64'hA3;
        b_valid = 1'b1; b_rd = 5'd4; b_data = 64'hB4;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("contend_rd", {123'b0, rd}, (i % 2 == 0) ? 128'd3 : 128'd4);
            check("contend_we", {127'b0, RegWrite}, 128'd1);
        end
        idle();
        tick();

        // x0 write is consumed and dropped
        b_valid = 1'b1; b_rd = 5'd0; b_data = 64'hFF;
        tick();
        check("x0_drop_pulse", {127'b0, x0_drop}, 128'd1);
        check("x0_no_write", {127'b0, RegWrite}, 128'd0);
        idle();
        tick();

        // Scoreboard set, hazard, clear
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        idle();
        chk_rs1 = 5'd7;
        tick();
        a_valid = 1'b1; a_rd = 5'd7; a_data = 64'h77;
        tick();
        idle();
        tick();
        check("sb_cleared", {127'b0, pending[7]}, 128'd0);
        // Same-cycle set and clear: set wins
        issue_valid = 1'b1; issue_rd = 5'd7;
        a_valid = 1'b1; a_rd = 5'd7; a_data = 64'h78;
        tick();
        idle();
        chk_rs2 = 5'd7;
        chk_rs1 = 5'd0;
        tick();
        check("sb_set_wins", {127'b0, pending[7]}, 128'd1);

        // Reset mid-flight
        a_valid = 1'b1; a_rd = 5'd9; a_data = 64'h99;
        issue_valid = 1'b1; issue_rd = 5'd12;
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_regwrite", {127'b0, RegWrite}, 128'd0);
        check("midrst_pending", {96'b0, pending}, 128'd0);
        tick();

        // Random traffic against the model
        for (int i = 0; i < 60; i++) begin
            a_valid     = 1'($urandom_range(0, 1));
            b_valid     = 1'($urandom_range(0, 1));
            issue_valid = 1'($urandom_range(0, 1));
            a_rd        = AW'($urandom_range(0, 7));
            b_rd        = AW'($urandom_range(0, 7));
            issue_rd    = AW'($urandom_range(0, 7));
            chk_rs1     = AW'($urandom_range(0, 7));
            chk_rs2     = AW'($urandom_range(0, 7));
            a_data      = {$urandom, $urandom};
            b_data      = {$urandom, $urandom};
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
